// File: rtl/rv_io_gpio_ng.sv
// GPIO controller on the RVOOM IO bus: synchronised and optionally filtered pad
// inputs, atomic output updates, and edge/level/both-edge interrupts.
module rv_io_gpio_ng #(
    parameter int RV    = 64,
    parameter int NPINS = 32,
    parameter int SYNC  = 2,
    parameter int DBW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             addr_req,
    output logic             addr_ack,
    input  logic             sel,
    input  logic [11:0]      addr,
    input  logic             read,
    input  logic [7:0]       mask,
    input  logic [RV-1:0]    wdata,
    output logic             data_req,
    input  logic             data_ack,
    output logic [RV-1:0]    rdata,
    output logic             interrupt,
    input  logic [NPINS-1:0] pad_in,
    output logic [NPINS-1:0] pad_out,
    output logic [NPINS-1:0] pad_oe,
    output logic [NPINS-1:0] pad_pu
);

    localparam logic [8:0] R_IN    = 9'd0;
    localparam logic [8:0] R_OUT   = 9'd1;
    localparam logic [8:0] R_SET   = 9'd2;
    localparam logic [8:0] R_CLR   = 9'd3;
    localparam logic [8:0] R_TOG   = 9'd4;
    localparam logic [8:0] R_DIR   = 9'd5;
    localparam logic [8:0] R_OD    = 9'd6;
    localparam logic [8:0] R_PU    = 9'd7;
    localparam logic [8:0] R_PEND  = 9'd8;
    localparam logic [8:0] R_IEN   = 9'd9;
    localparam logic [8:0] R_ITYPE = 9'd10;
    localparam logic [8:0] R_IPOL  = 9'd11;
    localparam logic [8:0] R_IBOTH = 9'd12;
    localparam logic [8:0] R_FEN   = 9'd13;
    localparam logic [8:0] R_FCNT  = 9'd14;
    localparam logic [8:0] R_RAW   = 9'd15;

    logic [8:0]       idx;
    logic             rd_en;
    logic             wr_en;
    logic [RV-1:0]    wmask;
    logic [NPINS-1:0] wen;
    logic [NPINS-1:0] wnew;
    logic [NPINS-1:0] wbits;

    logic [NPINS-1:0] out_r;
    logic [NPINS-1:0] dir_r;
    logic [NPINS-1:0] od_r;
    logic [NPINS-1:0] pu_r;
    logic [NPINS-1:0] pend_r;
    logic [NPINS-1:0] ien_r;
    logic [NPINS-1:0] itype_r;
    logic [NPINS-1:0] ipol_r;
    logic [NPINS-1:0] iboth_r;
    logic [NPINS-1:0] fen_r;
    logic [DBW-1:0]   fcnt_r;

    logic [SYNC-1:0][NPINS-1:0] sync_p0;
    logic [NPINS-1:0] raw;
    logic [NPINS-1:0] filt_p1;
    logic [NPINS-1:0] filt_p2;
    logic [NPINS-1:0] src;
    logic [NPINS-1:0] pend_clr;
    logic [NPINS-1:0] rd_pins;
    logic [RV-1:0]    rd_val;

    function automatic logic [NPINS-1:0] merge(input logic [NPINS-1:0] cur,
                                               input logic [NPINS-1:0] val,
                                               input logic [NPINS-1:0] en);
        return (cur & ~en) | (val & en);
    endfunction

    assign idx      = addr[11:3];
    assign addr_ack = addr_req & sel & ~(data_req & ~data_ack);
    assign rd_en    = addr_ack & read;
    assign wr_en    = addr_ack & ~read;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < RV; i++) wmask[i] = mask[i / 8];
    end

    assign wen   = wmask[NPINS-1:0];
    assign wnew  = wdata[NPINS-1:0];
    assign wbits = wnew & wen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_r   <= '0;
            dir_r   <= '0;
            od_r    <= '0;
            pu_r    <= '1;
            ien_r   <= '0;
            itype_r <= '0;
            ipol_r  <= '0;
            iboth_r <= '0;
            fen_r   <= '0;
            fcnt_r  <= '0;
        end else if (wr_en) begin
            case (idx)
                R_OUT:   out_r   <= merge(out_r, wnew, wen);
                R_SET:   out_r   <= out_r | wbits;
                R_CLR:   out_r   <= out_r & ~wbits;
                R_TOG:   out_r   <= out_r ^ wbits;
                R_DIR:   dir_r   <= merge(dir_r, wnew, wen);
                R_OD:    od_r    <= merge(od_r, wnew, wen);
                R_PU:    pu_r    <= merge(pu_r, wnew, wen);
                R_IEN:   ien_r   <= merge(ien_r, wnew, wen);
                R_ITYPE: itype_r <= merge(itype_r, wnew, wen);
                R_IPOL:  ipol_r  <= merge(ipol_r, wnew, wen);
                R_IBOTH: iboth_r <= merge(iboth_r, wnew, wen);
                R_FEN:   fen_r   <= merge(fen_r, wnew, wen);
                R_FCNT:  fcnt_r  <= (fcnt_r & ~wmask[DBW-1:0]) | (wdata[DBW-1:0] & wmask[DBW-1:0]);
                default: ;
            endcase
        end
    end

    // Stage p0: input synchroniser, newest sample in slot 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_p0 <= '0;
        else        sync_p0 <= {sync_p0[SYNC-2:0], pad_in};
    end

    assign raw = sync_p0[SYNC-1];

    // Stage p1: glitch filter; with the filter off or FCNT reached, F simply takes S
    for (genvar g = 0; g < NPINS; g++) begin : g_filt
        logic           f_bit;
        logic [DBW-1:0] cnt_p1;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                f_bit  <= 1'b0;
                cnt_p1 <= '0;
            end else if (!fen_r[g] || raw[g] == f_bit || cnt_p1 == fcnt_r) begin
                f_bit  <= raw[g];
                cnt_p1 <= '0;
            end else begin
                cnt_p1 <= cnt_p1 + 1'b1;
            end
        end

        assign filt_p1[g] = f_bit;
    end

    // Stage p2: previous filtered value for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) filt_p2 <= '0;
        else        filt_p2 <= filt_p1;
    end

    assign src = (itype_r & ~(filt_p1 ^ ipol_r))
               | (~itype_r & iboth_r & (filt_p1 ^ filt_p2))
               | (~itype_r & ~iboth_r & ipol_r & filt_p1 & ~filt_p2)
               | (~itype_r & ~iboth_r & ~ipol_r & ~filt_p1 & filt_p2);

    // A fresh source wins over a same-cycle write-1-clear
    assign pend_clr = (wr_en && idx == R_PEND) ? wbits : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r    <= '0;
            interrupt <= 1'b0;
        end else begin
            pend_r    <= (pend_r & ~pend_clr) | src;
            interrupt <= |(pend_r & ien_r);
        end
    end

    always_comb begin
        case (idx)
            R_IN:    rd_pins = filt_p1;
            R_OUT:   rd_pins = out_r;
            R_DIR:   rd_pins = dir_r;
            R_OD:    rd_pins = od_r;
            R_PU:    rd_pins = pu_r;
            R_PEND:  rd_pins = pend_r;
            R_IEN:   rd_pins = ien_r;
            R_ITYPE: rd_pins = itype_r;
            R_IPOL:  rd_pins = ipol_r;
            R_IBOTH: rd_pins = iboth_r;
            R_FEN:   rd_pins = fen_r;
            R_RAW:   rd_pins = raw;
            default: rd_pins = '0;
        endcase
        rd_val = '0;
        rd_val[NPINS-1:0] = rd_pins;
        if (idx == R_FCNT) rd_val[DBW-1:0] = fcnt_r;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_req <= 1'b0;
            rdata    <= '0;
        end else if (rd_en) begin
            data_req <= 1'b1;
            rdata    <= rd_val;
        end else if (data_ack) begin
            data_req <= 1'b0;
        end
    end

    // Open drain: the pad is only driven while the output is low
    assign pad_out = out_r;
    assign pad_oe  = dir_r & ~(od_r & out_r);
    assign pad_pu  = pu_r;

    logic unused_bus;
    assign unused_bus = ^{addr[2:0], wdata, wmask, mask};

endmodule
